register_file: RTL and testbench

- 32-entry integer register file for the RISC-V 64-bit single-cycle CPU; sits between decode and the ALU/writeback path.
- Two combinational read ports, one synchronous write port.
- x0 is hard-wired to zero.
- Registers x1..x11 are exported as dedicated debug outputs for bench/board observation.

---
 rtl/register_file.sv | 79 +++++++
 tb/tb_register_file.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// 32-entry RV64 integer register file: two combinational read ports, one synchronous write port, x0 fixed at zero.
// Optional same-cycle write-through forwarding on the read ports when REGFILE_WRITE_BYPASS_EN is defined.
module register_file #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  reg_write,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2,
    output logic [DATA_WIDTH-1:0] reg_x1,
    output logic [DATA_WIDTH-1:0] reg_x2,
    output logic [DATA_WIDTH-1:0] reg_x3,
    output logic [DATA_WIDTH-1:0] reg_x4,
    output logic [DATA_WIDTH-1:0] reg_x5,
    output logic [DATA_WIDTH-1:0] reg_x6,
    output logic [DATA_WIDTH-1:0] reg_x7,
    output logic [DATA_WIDTH-1:0] reg_x8,
    output logic [DATA_WIDTH-1:0] reg_x9,
    output logic [DATA_WIDTH-1:0] reg_x10,
    output logic [DATA_WIDTH-1:0] reg_x11
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    generate
        if (NUM_REGS < 12) begin : g_bad_addr_width
            $error("register_file: ADDR_WIDTH too small to hold x1..x11");
        end
    endgenerate

    // Zero initialiser keeps outputs defined before the first reset in simulation.
    logic [DATA_WIDTH-1:0] regs [NUM_REGS] = '{default: '0};

    logic write_en;
    assign write_en = reg_write && (write_reg != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            regs[write_reg] <= write_data;
        end
    end

    always_comb begin
        read_data1 = (read_reg1 == '0) ? '0 : regs[read_reg1];
        read_data2 = (read_reg2 == '0) ? '0 : regs[read_reg2];
`ifdef REGFILE_WRITE_BYPASS_EN
        // write_en already excludes x0, so forwarding can never make x0 non-zero.
        if (!rst && write_en && (read_reg1 == write_reg)) begin
            read_data1 = write_data;
        end
        if (!rst && write_en && (read_reg2 == write_reg)) begin
            read_data2 = write_data;
        end
`endif
    end

    assign reg_x1  = regs[1];
    assign reg_x2  = regs[2];
    assign reg_x3  = regs[3];
    assign reg_x4  = regs[4];
    assign reg_x5  = regs[5];
    assign reg_x6  = regs[6];
    assign reg_x7  = regs[7];
    assign reg_x8  = regs[8];
    assign reg_x9  = regs[9];
    assign reg_x10 = regs[10];
    assign reg_x11 = regs[11];

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus pushes expected read/debug values, a monitor pops and compares.
// Reference model is a plain array updated with the architectural rules; follows REGFILE_WRITE_BYPASS_EN too.
module tb_register_file;

    localparam int DW = 64;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] read_reg1 = '0;
    logic [AW-1:0] read_reg2 = '0;
    logic [AW-1:0] write_reg = '0;
    logic [DW-1:0] write_data = '0;
    logic          reg_write = 1'b0;
    logic [DW-1:0] read_data1;
    logic [DW-1:0] read_data2;
    logic [DW-1:0] dut_dbg [1:11];

    register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .reg_write  (reg_write),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .reg_x1     (dut_dbg[1]),
        .reg_x2     (dut_dbg[2]),
        .reg_x3     (dut_dbg[3]),
        .reg_x4     (dut_dbg[4]),
        .reg_x5     (dut_dbg[5]),
        .reg_x6     (dut_dbg[6]),
        .reg_x7     (dut_dbg[7]),
        .reg_x8     (dut_dbg[8]),
        .reg_x9     (dut_dbg[9]),
        .reg_x10    (dut_dbg[10]),
        .reg_x11    (dut_dbg[11])
    );

    always #5 clk = ~clk;

    typedef struct {
        string               name;
        logic [DW-1:0]       rd1;
        logic [DW-1:0]       rd2;
        logic [11:1][DW-1:0] dbg;
    } expect_t;

    expect_t       sb[$];
    logic [DW-1:0] model [32];
    int            checks = 0;
    int            errors = 0;

    function automatic logic [DW-1:0] modelRead(input logic [AW-1:0] addr, input logic r,
                                                input logic we, input logic [AW-1:0] wa,
                                                input logic [DW-1:0] wd);
        if (addr == 0) return '0;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (!r && we && wa != 0 && wa == addr) return wd;
`endif
        return model[addr];
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, record what the outputs must show before the edge, then retire the write.
    task automatic applyStimulus(input string name, input logic r, input logic we,
                                 input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                 input logic [AW-1:0] ra1, input logic [AW-1:0] ra2);
        expect_t e;
        @(negedge clk);
        rst = r; reg_write = we; write_reg = wa; write_data = wd;
        read_reg1 = ra1; read_reg2 = ra2;
        e.name = name;
        e.rd1  = modelRead(ra1, r, we, wa, wd);
        e.rd2  = modelRead(ra2, r, we, wa, wd);
        for (int k = 1; k <= 11; k++) e.dbg[k] = model[k];
        sb.push_back(e);
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < 32; k++) model[k] = '0;
        end else if (we && wa != 0) begin
            model[wa] = wd;
        end
    endtask

    initial begin : monitor
        expect_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput({e.name, " read_data1"}, read_data1, e.rd1);
                checkOutput({e.name, " read_data2"}, read_data2, e.rd2);
                for (int k = 1; k <= 11; k++)
                    checkOutput($sformatf("%s reg_x%0d", e.name, k), dut_dbg[k], e.dbg[k]);
            end
        end
    end

    initial begin : stimulus
        int drain;
        for (int k = 0; k < 32; k++) model[k] = '0;

        applyStimulus("power-up", 1'b0, 1'b0, 5'd0, '0, 5'd1, 5'd2);
        applyStimulus("pre-reset write", 1'b0, 1'b1, 5'd7, 64'h0123_4567_89AB_CDEF, 5'd7, 5'd0);
        applyStimulus("pre-reset write2", 1'b0, 1'b1, 5'd11, 64'h5555_AAAA_5555_AAAA, 5'd7, 5'd11);
        applyStimulus("reset", 1'b1, 1'b0, 5'd0, '0, 5'd7, 5'd11);
        applyStimulus("after reset", 1'b0, 1'b0, 5'd0, '0, 5'd7, 5'd11);
        applyStimulus("write x1", 1'b0, 1'b1, 5'd1, 64'hDEAD_BEEF_1234_5678, 5'd1, 5'd2);
        applyStimulus("write x2", 1'b0, 1'b1, 5'd2, 64'hCAFE_BABE_8765_4321, 5'd1, 5'd2);
        applyStimulus("read x1 x2", 1'b0, 1'b0, 5'd9, 64'hFFFF, 5'd1, 5'd2);
        applyStimulus("write x3", 1'b0, 1'b1, 5'd3, 64'h1234_5678_9ABC_DEF0, 5'd1, 5'd2);
        applyStimulus("read x3", 1'b0, 1'b0, 5'd0, '0, 5'd3, 5'd3);
        applyStimulus("write x0", 1'b0, 1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 5'd0);
        applyStimulus("read x0", 1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd1);
        applyStimulus("gated write x4", 1'b0, 1'b0, 5'd4, 64'h1111, 5'd4, 5'd4);
        applyStimulus("read x4", 1'b0, 1'b0, 5'd0, '0, 5'd4, 5'd3);
        applyStimulus("reset vs write x5", 1'b1, 1'b1, 5'd5, 64'h5A5A, 5'd5, 5'd1);
        applyStimulus("read x5", 1'b0, 1'b0, 5'd0, '0, 5'd5, 5'd1);
        applyStimulus("same-cycle x6", 1'b0, 1'b1, 5'd6, 64'hAB, 5'd6, 5'd6);
        applyStimulus("read x6", 1'b0, 1'b0, 5'd0, '0, 5'd6, 5'd0);

        for (int n = 0; n < 300; n++) begin
            applyStimulus($sformatf("random %0d", n),
                          ($urandom_range(0, 31) == 0),
                          ($urandom_range(0, 3) != 0),
                          5'($urandom_range(0, 15)),
                          {$urandom, $urandom},
                          5'($urandom_range(0, 31)),
                          5'($urandom_range(0, 15)));
        end

        drain = 0;
        while (sb.size() > 0 && drain < 10) begin
            @(negedge clk);
            drain++;
        end
        #5;
        if (sb.size() > 0) begin
            errors++;
            $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
